// File: rtl/hmmm_mem_responder_if.sv
// rtl/hmmm_mem_responder_if.sv - loader byte stream and I/O FIFO stream bundle for hmmm_mem_responder
interface hmmm_mem_responder_if;
   logic       ld_valid;
   logic [7:0] ld_data;
   logic       ld_ready;
   logic       ld_done;
   logic       io_valid;
   logic [7:0] io_data;
   logic       io_ready;
   logic       io_overflow;

   // loader source and I/O consumer side
   modport master (
      output ld_valid, ld_data, ld_done, io_ready,
      input  ld_ready, io_valid, io_data, io_overflow
   );

   // memory responder side
   modport slave (
      input  ld_valid, ld_data, ld_done, io_ready,
      output ld_ready, io_valid, io_data, io_overflow
   );
endinterface

// File: rtl/hmmm_mem_responder.sv
// rtl/hmmm_mem_responder.sv - HMMM instruction/data memory responder with byte loader and I/O FIFO (HMMM_MEM_IO_EN)
module hmmm_mem_responder #(
   parameter int         FIFO_DEPTH = 4,
   parameter logic [7:0] IO_ADDR    = 8'hFF
) (
   input  logic       clk,
   input  logic       reset_n,
   output logic       cpu_reset,
   input  logic [7:0] adr,
   input  logic       mem_write,
   output logic [6:0] mem_data1,
   inout  wire  [7:0] mem_data2,
   hmmm_mem_responder_if.slave bus
);

   localparam logic [1:0] S_LOAD_HI = 2'd0;
   localparam logic [1:0] S_LOAD_LO = 2'd1;
   localparam logic [1:0] S_RUN     = 2'd2;

   logic [1:0]  state_q, state_d;
   logic [7:0]  lp_q, lp_d;
   logic [6:0]  pend_q, pend_d;

   // 15-bit program/data words; contents survive reset
   logic [14:0] mem_q [256];
   logic        mem_we;
   logic [7:0]  mem_waddr;
   logic [14:0] mem_wdata;

   logic        loading;
   logic        run;
   logic        io_sel;
   logic        cpu_store;
   logic [7:0]  status;
   logic [14:0] rd_word;
   logic [6:0]  rd_hi;
   logic [7:0]  rd_lo;

   assign loading   = (state_q == S_LOAD_HI) || (state_q == S_LOAD_LO);
   assign run       = (state_q == S_RUN);
   assign cpu_reset = loading;
   assign rd_word   = mem_q[adr];
   assign cpu_store = run & mem_write & ~io_sel;

   // loader FSM and the single array write port shared by loader and core stores
   always_comb begin
      state_d   = state_q;
      lp_d      = lp_q;
      pend_d    = pend_q;
      mem_we    = 1'b0;
      mem_waddr = adr;
      mem_wdata = {rd_word[14:8], mem_data2};
      case (state_q)
         S_LOAD_HI: begin
            if (bus.ld_valid) begin
               pend_d  = bus.ld_data[6:0];
               state_d = S_LOAD_LO;
            end
            if (bus.ld_done) begin
               state_d = S_RUN;
            end
         end
         S_LOAD_LO: begin
            if (bus.ld_valid) begin
               mem_we    = 1'b1;
               mem_waddr = lp_q;
               mem_wdata = {pend_q, bus.ld_data};
               lp_d      = lp_q + 8'd1;
               state_d   = S_LOAD_HI;
            end
            if (bus.ld_done) begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            mem_we = cpu_store;
         end
         default: begin
            state_d = S_LOAD_HI;
         end
      endcase
   end

   // FSM, load pointer and pending high byte registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_LOAD_HI;
         lp_q    <= 8'd0;
         pend_q  <= 7'd0;
      end else begin
         state_q <= state_d;
         lp_q    <= lp_d;
         pend_q  <= pend_d;
      end
   end

   // array write port, no reset so program survives a core restart
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[mem_waddr] <= mem_wdata;
      end
   end

   // combinational read mux with the I/O status byte overlaid on IO_ADDR
   always_comb begin
      rd_hi = rd_word[14:8];
      rd_lo = rd_word[7:0];
      if (io_sel) begin
         rd_hi = 7'd0;
         rd_lo = status;
      end
   end

   assign mem_data1    = rd_hi;
   assign mem_data2    = mem_write ? 8'hzz : rd_lo;
   assign bus.ld_ready = loading;

`ifdef HMMM_MEM_IO_EN
   localparam int              PTR_W     = $clog2(FIFO_DEPTH);
   localparam logic [PTR_W:0]  DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);

   logic [7:0]       fifo_q [FIFO_DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]   cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic             fifo_full;
   logic             fifo_empty;
   logic             push_req;
   logic             push;
   logic             pop;

   assign io_sel     = (adr == IO_ADDR);
   assign fifo_empty = (cnt_q == '0);
   assign fifo_full  = (cnt_q == DEPTH_CNT);
   assign push_req   = run & mem_write & io_sel;
   assign pop        = ~fifo_empty & bus.io_ready;
   // a pop frees the slot the simultaneous push needs, so full only drops without a pop
   assign push       = push_req & (~fifo_full | pop);
   assign status     = {6'b0, fifo_full, fifo_empty};

   assign bus.io_valid    = ~fifo_empty;
   assign bus.io_data     = fifo_empty ? 8'h00 : fifo_q[rd_ptr_q];
   assign bus.io_overflow = ovf_q;

   // FIFO pointer, occupancy and sticky overflow next-state
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      cnt_d    = cnt_q;
      ovf_d    = ovf_q;
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + (PTR_W + 1)'(1);
         2'b01:   cnt_d = cnt_q - (PTR_W + 1)'(1);
         default: cnt_d = cnt_q;
      endcase
      if (push_req & fifo_full & ~pop) begin
         ovf_d = 1'b1;
      end
   end

   // FIFO control registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         cnt_q    <= cnt_d;
         ovf_q    <= ovf_d;
      end
   end

   // FIFO storage; emptiness masks stale entries so no reset is needed
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_q[wr_ptr_q] <= mem_data2;
      end
   end
`else
   logic unused_io;

   assign io_sel          = 1'b0;
   assign status          = 8'h00;
   assign bus.io_valid    = 1'b0;
   assign bus.io_data     = 8'h00;
   assign bus.io_overflow = 1'b0;
   assign unused_io       = bus.io_ready ^ (IO_ADDR != 8'h00) ^ (FIFO_DEPTH != 0);
`endif

endmodule

// File: tb/tb_hmmm_mem_responder.sv
// tb/tb_hmmm_mem_responder.sv - self-checking bench for hmmm_mem_responder (table vectors, corner sequences, random vs model)
module tb_hmmm_mem_responder;
   localparam int DEPTH = 4;
`ifdef HMMM_MEM_IO_EN
   localparam bit IO_EN = 1'b1;
`else
   localparam bit IO_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset_n;
   logic       cpu_reset;
   logic [7:0] adr;
   logic       mem_write;
   logic [7:0] wr_data;
   logic [6:0] mem_data1;
   wire  [7:0] mem_data2;

   hmmm_mem_responder_if bus();

   assign mem_data2 = mem_write ? wr_data : 8'hzz;

   hmmm_mem_responder #(.FIFO_DEPTH(DEPTH), .IO_ADDR(8'hFF)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .cpu_reset (cpu_reset),
      .adr       (adr),
      .mem_write (mem_write),
      .mem_data1 (mem_data1),
      .mem_data2 (mem_data2),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] want);
      n_checks++;
      if (act === want) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, want);
   endfunction

   // reference model: memory as plain arrays, loader as "have a high byte yet", FIFO as a queue
   bit [14:0] m_mem   [256];
   bit        m_known [256];
   bit        m_loading;
   bit        m_have_hi;
   bit [6:0]  m_pend;
   int        m_lp;
   bit [7:0]  m_q [$];
   bit        m_ovf;

   task automatic model_reset();
      m_loading = 1'b1;
      m_have_hi = 1'b0;
      m_lp      = 0;
      m_q.delete();
      m_ovf     = 1'b0;
   endtask

   task automatic model_edge();
      if (m_loading) begin
         if (bus.ld_valid) begin
            if (!m_have_hi) begin
               m_pend    = bus.ld_data[6:0];
               m_have_hi = 1'b1;
            end else begin
               m_mem[m_lp]   = {m_pend, bus.ld_data};
               m_known[m_lp] = 1'b1;
               m_lp          = (m_lp + 1) % 256;
               m_have_hi     = 1'b0;
            end
         end
         if (bus.ld_done) m_loading = 1'b0;
      end else begin
         if (IO_EN && m_q.size() > 0 && bus.io_ready) void'(m_q.pop_front());
         if (mem_write) begin
            if (IO_EN && adr == 8'hFF) begin
               if (m_q.size() < DEPTH) m_q.push_back(wr_data);
               else m_ovf = 1'b1;
            end else begin
               m_mem[adr][7:0] = wr_data;
            end
         end
      end
   endtask

   task automatic check_outputs(input string tag);
      check({tag, " cpu_reset"}, cpu_reset, m_loading);
      check({tag, " ld_ready"}, bus.ld_ready, m_loading);
      check({tag, " io_valid"}, bus.io_valid, m_q.size() != 0);
      check({tag, " io_data"}, bus.io_data, (m_q.size() != 0) ? m_q[0] : 8'h00);
      check({tag, " io_overflow"}, bus.io_overflow, m_ovf);
      if (!mem_write) begin
         if (IO_EN && adr == 8'hFF) begin
            check({tag, " status d1"}, mem_data1, 7'h00);
            check({tag, " status d2"}, mem_data2, {6'b0, m_q.size() == DEPTH, m_q.size() == 0});
         end else if (m_known[adr]) begin
            check({tag, " d1"}, mem_data1, m_mem[adr][14:8]);
            check({tag, " d2"}, mem_data2, m_mem[adr][7:0]);
         end
      end
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.ld_valid = 1'b0;
      bus.ld_data  = 8'h00;
      bus.ld_done  = 1'b0;
      bus.io_ready = 1'b0;
      mem_write    = 1'b0;
      adr          = 8'h00;
      wr_data      = 8'h00;
   endtask

   task automatic do_reset(input string tag);
      idle_inputs();
      reset_n = 1'b0;
      #1;
      check({tag, " rst cpu_reset"}, cpu_reset, 1'b1);
      check({tag, " rst ld_ready"}, bus.ld_ready, 1'b1);
      check({tag, " rst io_valid"}, bus.io_valid, 1'b0);
      check({tag, " rst io_overflow"}, bus.io_overflow, 1'b0);
      model_reset();
      @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   task automatic store(input logic [7:0] a, input logic [7:0] d);
      mem_write = 1'b1;
      adr       = a;
      wr_data   = d;
      tick();
      mem_write = 1'b0;
   endtask

   function automatic bit [14:0] wordval(input int i);
      bit [14:0] w;
      w[14:8] = 7'(i * 5 + 3);
      w[7:0]  = 8'(i * 37 + 11 + (i >> 8) * 64);
      return w;
   endfunction

   typedef struct {
      bit       ld_valid;
      bit [7:0] ld_data;
      bit       ld_done;
      bit       mem_write;
      bit [7:0] adr;
      bit [7:0] wdata;
      bit       exp_cpu_reset;
      bit       exp_ld_ready;
      bit       chk_rd;
      bit [6:0] exp_d1;
      bit [7:0] exp_d2;
   } vec_t;

   vec_t vecs [$];

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit [14:0] w;
      bit [14:0] w256;
      w256 = wordval(256);

      vecs.push_back('{1, 8'h2A, 0, 0, 8'h00, 8'h00, 1, 1, 0, 7'h00, 8'h00});
      vecs.push_back('{1, 8'h55, 0, 0, 8'h00, 8'h00, 1, 1, 0, 7'h00, 8'h00});
      vecs.push_back('{1, 8'h83, 0, 0, 8'h00, 8'h00, 1, 1, 0, 7'h00, 8'h00});
      vecs.push_back('{1, 8'h01, 0, 0, 8'h00, 8'h00, 1, 1, 0, 7'h00, 8'h00});
      vecs.push_back('{0, 8'h00, 1, 0, 8'h00, 8'h00, 1, 1, 0, 7'h00, 8'h00});
      vecs.push_back('{0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 1, 7'h2A, 8'h55});
      vecs.push_back('{0, 8'h00, 0, 0, 8'h01, 8'h00, 0, 0, 1, 7'h03, 8'h01});
      vecs.push_back('{0, 8'h00, 0, 1, 8'h01, 8'hC4, 0, 0, 0, 7'h00, 8'h00});
      vecs.push_back('{0, 8'h00, 0, 0, 8'h01, 8'h00, 0, 0, 1, 7'h03, 8'hC4});
      vecs.push_back('{1, 8'hEE, 1, 0, 8'h00, 8'h00, 0, 0, 1, 7'h2A, 8'h55});
      vecs.push_back('{0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 1, 7'h2A, 8'h55});

      // power-on reset values
      idle_inputs();
      reset_n = 1'b0;
      #12;
      check("reset cpu_reset", cpu_reset, 1'b1);
      check("reset ld_ready", bus.ld_ready, 1'b1);
      check("reset io_valid", bus.io_valid, 1'b0);
      check("reset io_data", bus.io_data, 8'h00);
      check("reset io_overflow", bus.io_overflow, 1'b0);
      model_reset();
      @(posedge clk);
      #1;
      reset_n = 1'b1;

      // table: load two words, end loading, fetch and store
      for (int i = 0; i < vecs.size(); i++) begin
         bus.ld_valid = vecs[i].ld_valid;
         bus.ld_data  = vecs[i].ld_data;
         bus.ld_done  = vecs[i].ld_done;
         mem_write    = vecs[i].mem_write;
         adr          = vecs[i].adr;
         wr_data      = vecs[i].wdata;
         #1;
         check($sformatf("vec%0d cpu_reset", i), cpu_reset, vecs[i].exp_cpu_reset);
         check($sformatf("vec%0d ld_ready", i), bus.ld_ready, vecs[i].exp_ld_ready);
         if (vecs[i].chk_rd) begin
            check($sformatf("vec%0d d1", i), mem_data1, vecs[i].exp_d1);
            check($sformatf("vec%0d d2", i), mem_data2, vecs[i].exp_d2);
         end
         tick();
      end
      idle_inputs();

      // 257 words: the last one wraps onto array[0]
      do_reset("wrap");
      for (int i = 0; i <= 256; i++) begin
         w = wordval(i);
         bus.ld_valid = 1'b1;
         bus.ld_data  = {1'b1, w[14:8]};
         tick();
         bus.ld_data  = w[7:0];
         tick();
      end
      bus.ld_valid = 1'b0;
      bus.ld_done  = 1'b1;
      tick();
      bus.ld_done  = 1'b0;
      adr = 8'h00;
      #1;
      check("wrap cpu_reset", cpu_reset, 1'b0);
      check("wrap adr0 d1", mem_data1, w256[14:8]);
      check("wrap adr0 d2", mem_data2, w256[7:0]);
      w = wordval(255);
      adr = 8'hFE;
      #1;
      w = wordval(254);
      check("wrap adr254 d2", mem_data2, w[7:0]);

      // lone high byte then ld_done leaves the array untouched
      do_reset("lone");
      bus.ld_valid = 1'b1;
      bus.ld_data  = 8'hFF;
      tick();
      bus.ld_valid = 1'b0;
      bus.ld_done  = 1'b1;
      tick();
      bus.ld_done  = 1'b0;
      adr = 8'h00;
      #1;
      check("lone cpu_reset", cpu_reset, 1'b0);
      check("lone adr0 d1", mem_data1, w256[14:8]);
      check("lone adr0 d2", mem_data2, w256[7:0]);

      // five stores to the I/O address with the consumer stalled
      for (int k = 0; k < 5; k++) store(8'hFF, 8'(8'h10 + k));
      adr = 8'hFF;
      #1;
`ifdef HMMM_MEM_IO_EN
      check("fifo overflow", bus.io_overflow, 1'b1);
      check("fifo status d1", mem_data1, 7'h00);
      check("fifo status d2", mem_data2, 8'h02);
      bus.io_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         check($sformatf("fifo pop%0d valid", k), bus.io_valid, 1'b1);
         check($sformatf("fifo pop%0d data", k), bus.io_data, 8'(8'h10 + k));
         tick();
      end
      check("fifo drained valid", bus.io_valid, 1'b0);
      bus.io_ready = 1'b0;

      // full FIFO: pop and push in the same cycle, no overflow
      do_reset("simul");
      bus.ld_done = 1'b1;
      tick();
      bus.ld_done = 1'b0;
      for (int k = 0; k < 4; k++) store(8'hFF, 8'(8'h20 + k));
      adr = 8'hFF;
      #1;
      check("simul full status", mem_data2, 8'h02);
      bus.io_ready = 1'b1;
      store(8'hFF, 8'h99);
      #1;
      check("simul overflow", bus.io_overflow, 1'b0);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("simul pop%0d data", k), bus.io_data, (k == 3) ? 8'h99 : 8'(8'h21 + k));
         tick();
         #1;
      end
      check("simul drained valid", bus.io_valid, 1'b0);
      bus.io_ready = 1'b0;
`else
      check("noio io_valid", bus.io_valid, 1'b0);
      check("noio io_overflow", bus.io_overflow, 1'b0);
      check("noio adrFF d2", mem_data2, 8'h14);
`endif

      // reset mid-run keeps the array, reset mid-load restarts at lp=0
      do_reset("midrun");
      adr = 8'h00;
      #1;
      check("midrun adr0 d1", mem_data1, w256[14:8]);
      check("midrun adr0 d2", mem_data2, w256[7:0]);
      bus.ld_valid = 1'b1;
      bus.ld_data  = 8'h11;
      tick();
      do_reset("midload");
      bus.ld_valid = 1'b1;
      bus.ld_data  = 8'h12;
      tick();
      bus.ld_data  = 8'h34;
      tick();
      bus.ld_valid = 1'b0;
      bus.ld_done  = 1'b1;
      tick();
      bus.ld_done  = 1'b0;
      adr = 8'h00;
      #1;
      check("midload adr0 d1", mem_data1, 7'h12);
      check("midload adr0 d2", mem_data2, 8'h34);
      w = wordval(1);
      adr = 8'h01;
      #1;
      check("midload adr1 d2", mem_data2, w[7:0]);

      // randomized load then run against the model
      do_reset("rnd");
      for (int c = 0; c < 60 && m_loading; c++) begin
         bus.ld_valid = ($urandom_range(0, 9) < 7);
         bus.ld_data  = 8'($urandom);
         bus.ld_done  = (c == 41);
         mem_write    = $urandom_range(0, 1);
         adr          = 8'($urandom_range(0, 31));
         wr_data      = 8'($urandom);
         #1;
         check_outputs($sformatf("rndload c%0d", c));
         tick();
      end
      for (int c = 0; c < 400; c++) begin
         bus.ld_valid = $urandom_range(0, 1);
         bus.ld_data  = 8'($urandom);
         bus.ld_done  = ($urandom_range(0, 7) == 0);
         bus.io_ready = $urandom_range(0, 1);
         mem_write    = ($urandom_range(0, 9) < 4);
         adr          = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 31));
         wr_data      = 8'($urandom);
         #1;
         check_outputs($sformatf("rndrun c%0d", c));
         tick();
      end
      idle_inputs();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/hmmm_mem_responder.md
# hmmm_mem_responder

Memory-side responder for the 8-bit HMMM core's split instruction/data bus. It serves 15-bit instruction fetches and 8-bit data reads/writes from a 256-word array. A byte-serial loader fills program memory while it holds the core in reset. Stores to a reserved I/O address are pushed into a small output FIFO with a valid/ready handshake.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: entries in the I/O output FIFO; power of two, ≥2.
- `IO_ADDR`, 8'hFF: data address mapped to the I/O FIFO and status byte.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cpu_reset`  out  1  active-high reset to the core; high while loading.
- `adr`  in  8  bus address from the core.
- `mem_write`  in  1  core store strobe.
- `mem_data1`  out  7  instruction word bits [14:8] at `adr`.
- `mem_data2`  inout  8  word bits [7:0] at `adr`.
  - Driven by this block when `mem_write`=0.
  - High-Z when `mem_write`=1, so the core drives store data.
- `ld_valid`  in  1  loader byte valid.
- `ld_data`  in  8  loader byte.
- `ld_ready`  out  1  loader byte accepted when `ld_valid & ld_ready`.
- `ld_done`  in  1  single-cycle pulse that ends loading.
- `io_valid`  out  1  FIFO head valid.
- `io_data`  out  8  FIFO head byte.
- `io_ready`  in  1  consumer pops the head when `io_valid & io_ready`.
- `io_overflow`  out  1  sticky: a store was dropped because the FIFO was full.

## Operation
FSM states: LOAD_HI, LOAD_LO, RUN. Reset enters LOAD_HI with load pointer `lp`=0.

LOAD_HI:
- Accepted byte: bits [6:0] latch as pending word[14:8]; bit 7 is ignored. Go to LOAD_LO.
- `ld_done`: go to RUN.

LOAD_LO:
- Accepted byte: write {pending, byte} to array[`lp`]; `lp` += 1 mod 256 (255 wraps to 0). Go to LOAD_HI.
- `ld_done`: discard the partial word, go to RUN.
- `ld_done` in the same cycle as an accepted byte: the byte is processed first, then the FSM goes to RUN.

RUN:
- Terminal until `reset_n` is asserted.
- `ld_ready`=0; `ld_valid` and `ld_done` are ignored.

Other outputs by state:
- `ld_ready`=1 in LOAD_HI and LOAD_LO.
- `cpu_reset`=1 in LOAD_HI and LOAD_LO, 0 in RUN.

Reads (combinational, every state):
- `mem_data1` = array[`adr`][14:8].
- `mem_data2` = array[`adr`][7:0] when `mem_write`=0.
- Exception, `adr`==`IO_ADDR`: `mem_data1`=0 and `mem_data2`={6'b0, fifo_full, fifo_empty}.

Stores (RUN only; `mem_write` is ignored while `cpu_reset`=1):
- `adr`≠`IO_ADDR`: array[`adr`][7:0] ← `mem_data2` at the edge; bits [14:8] are preserved.
- `adr`==`IO_ADDR`: push `mem_data2` into the FIFO.
  - If the FIFO is full and no pop happens this cycle: drop the byte and set `io_overflow`.
  - A push and a pop in the same cycle with the FIFO full: both occur, no overflow.

FIFO:
- First-word fall-through; `io_data` = head entry.
- Count width is $clog2(`FIFO_DEPTH`)+1.
- Pointers wrap modulo `FIFO_DEPTH`.

## Timing
- Array contents are not reset.
- Reset values:
  - `cpu_reset`=1, `ld_ready`=1.
  - FIFO empty, `io_valid`=0, `io_data`=0.
  - `io_overflow`=0.
- Read latency: zero cycles (combinational from `adr`).
- Write latency: the array updates at the edge, visible to a read in the next cycle.
- Loader throughput: one byte per cycle, two cycles per word.
- `ld_done` sampled at edge N: RUN from edge N, `cpu_reset` low in cycle N+1.
- FIFO push at edge N: `io_valid` high in cycle N+1.
- Asserting `reset_n` mid-load or mid-run returns to LOAD_HI, `lp`=0, FIFO empty, overflow cleared. Array contents are retained.

## Configuration
- `HMMM_MEM_IO_EN` defined: I/O FIFO, status read and `io_overflow` behave as above.
- `HMMM_MEM_IO_EN` undefined:
  - `IO_ADDR` is ordinary memory.
  - `io_valid` and `io_overflow` are tied 0; `io_data` is tied 0.
  - `io_ready` is ignored.
  - No FIFO storage is built.

## Test plan
- Load: bytes 0x2A,0x55, 0x83,0x01, then `ld_done` → array[0]=15'h2A55, array[1]=15'h0301, `cpu_reset` falls one cycle after `ld_done`, `ld_ready`=0.
- Fetch/store: `adr`=0x01, `mem_write`=0 → `mem_data1`=7'h03, `mem_data2`=0x01. Store 0xC4 to 0x01, then read → `mem_data1`=7'h03, `mem_data2`=0xC4.
- Loader boundaries: 257 words loaded → word 256 overwrites array[0]. `ld_done` after a lone high byte → partial word discarded, array unchanged.
- I/O FIFO (`FIFO_DEPTH`=4, `io_ready`=0): 5 stores of 0x10..0x14 to 0xFF → 0x10..0x13 held, `io_overflow`=1, status read = 0x02. Raise `io_ready` → 0x10,0x11,0x12,0x13 in order, then `io_valid`=0.
- Full FIFO with `io_ready`=1 and a store of 0x99 in the same cycle → pop and push both occur, `io_overflow` stays 0.
- Reset: `reset_n` pulsed low mid-load and mid-run → `cpu_reset`=1, state LOAD_HI, `lp`=0, `io_valid`=0, and array[0] still reads back its old value.
